// File: rtl/dt_pkg.sv
// dt_pkg: image geometry, address widths and FSM states shared by the DT engine and the binarize-and-pack block.
package dt_pkg;
    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int WORD_W = 16;
    localparam int PIX_AW = 14;
    localparam int WRD_AW = 10;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NWORDS = NPIX / WORD_W;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH, S_DONE} state_t;
endpackage

// File: rtl/dt_bin_pack_if.sv
// dt_bin_pack_if: controller handshake, result-RAM read port and output-memory write port of the pack engine.
interface dt_bin_pack_if;
    import dt_pkg::*;
    logic              start;
    logic [7:0]        thr;
    logic              busy;
    logic              done;
    logic [14:0]       ones_cnt;
    logic              res_rd;
    logic [PIX_AW-1:0] res_addr;
    logic [7:0]        res_di;
    logic              sto_wr;
    logic [WRD_AW-1:0] sto_addr;
    logic [WORD_W-1:0] sto_do;
    modport master (output start, thr, res_di,
                    input  busy, done, ones_cnt, res_rd, res_addr, sto_wr, sto_addr, sto_do);
    modport slave  (input  start, thr, res_di,
                    output busy, done, ones_cnt, res_rd, res_addr, sto_wr, sto_addr, sto_do);
endinterface

// File: rtl/dt_bit_packer.sv
// dt_bit_packer: MSB-first 16-bit shift packer; registers the full word and a one-cycle valid on the 16th bit.
module dt_bit_packer
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic              i_bit,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word
);
    logic [WORD_W-1:0] r_sr;
    logic [3:0]        r_cnt;
    logic              r_valid;
    logic [WORD_W-1:0] r_word;
    logic              w_full;
    assign w_full = i_en && r_cnt == 4'd15;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_word  <= '0;
        end else if (i_clr) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_word  <= '0;
        end else begin
            r_valid <= w_full;
            if (i_en) begin
                r_sr  <= {r_sr[WORD_W-2:0], i_bit};
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_full) r_word <= {r_sr[WORD_W-2:0], i_bit};
        end
    end
    assign o_word_valid = r_valid;
    assign o_word       = r_word;
endmodule

// File: rtl/dt_bin_pack.sv
// dt_bin_pack: reads the 128x128 result map, thresholds each pixel and writes MSB-first 16-pixel words.
module dt_bin_pack
    import dt_pkg::*;
(
    input logic         clk,
    input logic         reset,
    dt_bin_pack_if.slave bus
);
    localparam logic [PIX_AW-1:0] LAST_PIX = PIX_AW'(NPIX - 1);
    localparam logic [WRD_AW-1:0] LAST_WRD = WRD_AW'(NWORDS - 1);
    state_t            r_state, w_next;
    logic [7:0]        r_thr;
    logic [14:0]       r_ones;
    logic [PIX_AW-1:0] r_res_addr;
    logic [WRD_AW-1:0] r_sto_addr;
    logic              r_res_rd, r_vld, r_busy, r_done;
    logic              w_go, w_bit, w_last_pix, w_last_wr, w_word_valid;
    logic [WORD_W-1:0] w_word;
    always_comb begin
        w_go       = bus.start && (r_state == S_IDLE || r_state == S_DONE);
        w_bit      = bus.res_di >= r_thr;
        w_last_pix = r_res_addr == LAST_PIX;
        w_last_wr  = w_word_valid && r_sto_addr == LAST_WRD;
        w_next     = w_go ? S_FETCH :
                     (r_state == S_FETCH && w_last_pix) ? S_FLUSH :
                     (r_state == S_FLUSH && w_last_wr) ? S_DONE : r_state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end
    // r_vld marks the cycle the RAM returns data for the address issued one cycle earlier
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_thr      <= '0;
            r_ones     <= '0;
            r_res_addr <= '0;
            r_sto_addr <= '0;
            r_res_rd   <= 1'b0;
            r_vld      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (w_go) begin
            r_thr      <= bus.thr;
            r_ones     <= '0;
            r_res_addr <= '0;
            r_sto_addr <= '0;
            r_res_rd   <= 1'b1;
            r_vld      <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_vld <= r_res_rd;
            if (r_state == S_FETCH) begin
                r_res_rd <= !w_last_pix;
                if (!w_last_pix) r_res_addr <= r_res_addr + 1'b1;
            end
            if (r_vld && w_bit) r_ones <= r_ones + 15'd1;
            if (w_word_valid && !w_last_wr) r_sto_addr <= r_sto_addr + 1'b1;
            if (r_state == S_FLUSH && w_next == S_DONE) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end
    dt_bit_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clr        (w_go),
        .i_en         (r_vld),
        .i_bit        (w_bit),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.ones_cnt = r_ones;
    assign bus.res_rd   = r_res_rd;
    assign bus.res_addr = r_res_addr;
    assign bus.sto_wr   = w_word_valid;
    assign bus.sto_addr = r_sto_addr;
    assign bus.sto_do   = w_word;
endmodule
